// File: rtl/pwm_pkg.sv
// pwm_pkg: shared index-width helper, period length and stagger mode encodings for pwm_multi
package pwm_pkg;
  localparam int STAG_EDGE = 0;
  localparam int STAG_PHASE = 1;
  function automatic int idx_w(input int n);
    return n <= 1 ? 1 : $clog2(n);
  endfunction
  function automatic int period_len(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler, period counter, wrap strobe and registered period_end pulse
module pwm_timebase import pwm_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic [WIDTH-1:0] cnt,
  output logic wrap,
  output logic period_end
);
  localparam int PW = idx_w(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(period_len(WIDTH) - 1);
  logic [PW-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic tick, period_end_q;
  always_comb begin
    tick = en && pre_q == PRE_LAST;
    wrap = tick && cnt_q == CNT_LAST;
    pre_d = !en || tick ? '0 : pre_q + 1'b1;
    cnt_d = !en || wrap ? '0 : cnt_q + WIDTH'(tick);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
      period_end_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      period_end_q <= wrap;
    end
  end
  assign cnt = cnt_q;
  assign period_end = period_end_q;
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with shadowed duty registers, optional phase stagger and write error flag
module pwm_multi import pwm_pkg::*; #(
  parameter int CHANNELS = 5,
  parameter int WIDTH = 8,
  parameter int PRESCALE = 1,
  parameter int STAGGER = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic wr_valid,
  output logic wr_ready,
  input  logic [idx_w(CHANNELS)-1:0] wr_ch,
  input  logic [WIDTH-1:0] wr_duty,
  output logic [CHANNELS-1:0] out,
  output logic period_end,
  output logic wr_err
);
  localparam int CW = idx_w(CHANNELS);
  localparam int PER = period_len(WIDTH);
  localparam int STEP = PER / CHANNELS;
  logic [WIDTH-1:0] cnt;
  logic wrap, wr_acc, wr_in, wr_err_q, wr_err_d;
  logic [CHANNELS-1:0] out_q, out_d;
  pwm_timebase #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) u_timebase (
    .clk(clk),
    .rst(rst),
    .en(en),
    .cnt(cnt),
    .wrap(wrap),
    .period_end(period_end)
  );
  always_comb begin
    wr_ready = !rst;
    wr_acc = wr_valid && wr_ready;
    wr_in = {1'b0, wr_ch} < (CW + 1)'(CHANNELS);
    wr_err_d = wr_acc && !wr_in;
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [WIDTH:0] OFF = (WIDTH + 1)'(STAGGER == STAG_PHASE ? i * STEP : 0);
    localparam logic [WIDTH:0] PER_W = (WIDTH + 1)'(PER);
    logic [WIDTH-1:0] shadow_q, shadow_d, active_q, active_d, phase;
    logic [WIDTH:0] sum;
    always_comb begin
      shadow_d = wr_acc && wr_in && wr_ch == CW'(i) ? wr_duty : shadow_q;
      active_d = !en || wrap ? shadow_d : active_q;
      sum = {1'b0, cnt} + OFF;
      phase = WIDTH'(sum >= PER_W ? sum - PER_W : sum);
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
      end
    end
    assign out_d[i] = en && ch_en[i] && phase < active_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      wr_err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      wr_err_q <= wr_err_d;
    end
  end
  assign out = out_q;
  assign wr_err = wr_err_q;
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: table-driven duty checks plus hand sequences for shadow timing, reset and stagger
module tb_pwm_multi;
  logic clk, rst, en, en2, wr_valid;
  logic [4:0] ch_en;
  logic [2:0] wr_ch;
  logic [7:0] wr_duty;
  logic wr_ready, period_end, wr_err, wr_ready2, pe2, wr_err2;
  logic [4:0] out, out2, prev;
  int total = 0;
  int bad = 0;
  int cnt [5];
  int h [3];
  int r [5];
  int pe_n, n1, n2, npe, pe_a, pe_b;
  typedef struct {
    int ch;
    int duty;
    logic [4:0] ce;
    int err;
    int e [5];
  } vec_t;
  vec_t v [8];
  pwm_multi dut (
    .clk(clk), .rst(rst), .en(en), .ch_en(ch_en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_duty(wr_duty), .out(out), .period_end(period_end), .wr_err(wr_err)
  );
  pwm_multi #(.CHANNELS(5), .WIDTH(8), .PRESCALE(4), .STAGGER(1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .ch_en(5'h1f), .wr_valid(wr_valid), .wr_ready(wr_ready2),
    .wr_ch(wr_ch), .wr_duty(wr_duty), .out(out2), .period_end(pe2), .wr_err(wr_err2)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic wr(input int ch, input int d);
    wr_valid = 1'b1;
    wr_ch = 3'(ch);
    wr_duty = 8'(d);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask
  initial begin
    v[0] = '{0, 10, 5'h1f, 0, '{10, 0, 0, 0, 0}};
    v[1] = '{1, 0, 5'h1f, 0, '{10, 0, 0, 0, 0}};
    v[2] = '{2, 255, 5'h1f, 0, '{10, 0, 255, 0, 0}};
    v[3] = '{3, 128, 5'h1f, 0, '{10, 0, 255, 128, 0}};
    v[4] = '{7, 99, 5'h1f, 1, '{10, 0, 255, 128, 0}};
    v[5] = '{4, 1, 5'h1f, 0, '{10, 0, 255, 128, 1}};
    v[6] = '{5, 50, 5'h1f, 1, '{10, 0, 255, 128, 1}};
    v[7] = '{0, 10, 5'h17, 0, '{10, 0, 255, 0, 1}};
    rst = 1'b1;
    en = 1'b0;
    en2 = 1'b0;
    ch_en = 5'h1f;
    wr_valid = 1'b0;
    wr_ch = '0;
    wr_duty = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", int'(out), 0);
    chk("rst_period_end", int'(period_end), 0);
    chk("rst_wr_err", int'(wr_err), 0);
    chk("rst_wr_ready", int'(wr_ready), 0);
    rst = 1'b0;
    #1 chk("wr_ready", int'(wr_ready), 1);
    @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      en = 1'b0;
      ch_en = v[n].ce;
      wr(v[n].ch, v[n].duty);
      chk($sformatf("v%0d_wr_err", n), int'(wr_err), v[n].err);
      @(negedge clk);
      chk($sformatf("v%0d_wr_err_clear", n), int'(wr_err), 0);
      en = 1'b1;
      cnt = '{0, 0, 0, 0, 0};
      pe_n = 0;
      repeat (255) begin
        @(negedge clk);
        for (int i = 0; i < 5; i++) cnt[i] += int'(out[i]);
        pe_n += int'(period_end);
      end
      for (int i = 0; i < 5; i++) chk($sformatf("v%0d_high_ch%0d", n, i), cnt[i], v[n].e[i]);
      chk($sformatf("v%0d_period_end", n), pe_n, 1);
    end
    en = 1'b0;
    ch_en = 5'h1f;
    @(negedge clk);
    en = 1'b1;
    h = '{0, 0, 0};
    n1 = 0;
    n2 = 0;
    npe = 0;
    for (int k = 1; k <= 770; k++) begin
      @(negedge clk);
      if (k <= 765) h[(k - 1) / 255] += int'(out[0]);
      if (out[1]) n1++;
      if (!out[2]) n2++;
      if (period_end != (k % 255 == 0)) npe++;
      wr_valid = k == 50 || k == 509;
      wr_ch = 3'd0;
      wr_duty = k == 50 ? 8'd200 : 8'd77;
    end
    wr_valid = 1'b0;
    chk("mid_write_cur_period", h[0], 10);
    chk("mid_write_next_period", h[1], 200);
    chk("wrap_write_same_period", h[2], 77);
    chk("duty0_never_high", n1, 0);
    chk("duty255_never_low", n2, 0);
    chk("period_end_spacing", npe, 0);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", int'(out), 0);
    chk("midrst_period_end", int'(period_end), 0);
    chk("midrst_wr_ready", int'(wr_ready), 0);
    rst = 1'b0;
    n1 = 0;
    h[0] = 0;
    pe_a = -1;
    for (int k = 1; k <= 770; k++) begin
      @(negedge clk);
      if (k <= 510 && out != 5'd0) n1++;
      if (k > 510 && out[4:1] != 4'd0) n1++;
      if (k > 510 && k <= 765) h[0] += int'(out[0]);
      if (period_end && pe_a < 0) pe_a = k;
      wr_valid = k == 300;
      wr_ch = 3'd0;
      wr_duty = 8'd10;
    end
    wr_valid = 1'b0;
    chk("postrst_outputs_low", n1, 0);
    chk("postrst_first_wrap", pe_a, 255);
    chk("postrst_write_next_period", h[0], 10);
    en = 1'b0;
    for (int i = 0; i < 5; i++) wr(i, 51);
    en2 = 1'b1;
    prev = '0;
    r = '{-1, -1, -1, -1, -1};
    pe_a = -1;
    pe_b = -1;
    n2 = 0;
    for (int k = 1; k <= 2100; k++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) if (out2[i] && !prev[i] && r[i] < 0) r[i] = k;
      prev = out2;
      if (pe2 && pe_a < 0) pe_a = k;
      else if (pe2 && pe_b < 0) pe_b = k;
      if (k <= 1020) n2 += int'(out2[2]);
    end
    chk("stag_first_rise_ch0", r[0], 1);
    chk("stag_rise_ch4", r[4] - r[0], 204);
    chk("stag_rise_ch3", r[3] - r[0], 408);
    chk("stag_rise_ch2", r[2] - r[0], 612);
    chk("stag_rise_ch1", r[1] - r[0], 816);
    chk("stag_first_wrap", pe_a, 1020);
    chk("stag_period", pe_b - pe_a, 1020);
    chk("stag_high_ch2", n2, 204);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
